sevenseg_mux: RTL and testbench
===============================

# sevenseg_mux

Parametrised, time-multiplexed driver for a common-anode seven-segment display bank of DIGITS digits. It decodes each 4-bit value in hex or decimal mode, with per-digit decimal point and blanking, optional leading-zero suppression, and PWM brightness control. A guard interval between digit slots prevents ghosting. Input values are double-buffered and swapped only at frame boundaries, so a multi-digit update never tears. The block sits between the UART/datapath status logic and the board's segment/anode pins.

## Interface
- DIGITS, 8: number of digits driven (2..16).
- PRESCALE, 12500: clock cycles per digit slot (≥ GUARD+2).
- GUARD, 4: cycles at the start of each slot during which all anodes are off.
- BRIGHT_W, 4: width of the brightness control.

- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  capture digits_in/dp_in/blank_in into the shadow registers
- digits_in  in  4*DIGITS  digit k = digits_in[4k+3:4k]; digit 0 is rightmost
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit
- blank_in  in  DIGITS  1 = digit dark (segments and dp)
- hex_en  in  1  1 = hex glyphs 0–F; 0 = decimal, codes 10–15 show a dash
- lz_en  in  1  leading-zero suppression enable
- bright  in  BRIGHT_W  duty control; all-ones = full on
- seg  out  7  {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low
- an  out  DIGITS  anode enables, active low, at most one low
- frame_tick  out  1  one-cycle pulse at the start of each frame

## Operation
- **Slot counter (pcnt).** Counts 0..PRESCALE-1, then wraps.
- **Digit index (idx).** Advances on each pcnt wrap and wraps from DIGITS-1 to 0. The frame boundary is the cycle where both counters wrap to 0.
- **Shadow registers.** On load, digits_in, dp_in and blank_in are captured into them.
- **Display registers.** Copied from the shadow registers at the frame boundary. If load coincides with the boundary, the incoming load values go directly to the display registers.
- **Glyphs, active low (gfedcba).**
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000.
  - A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
  - Dash 0111111; blank 1111111.
- **Leading-zero suppression.** When lz_en=1, a digit k>0 is blanked if it and every digit above it are 0. Digit 0 is never suppressed. Suppression acts on segments only; the dp still follows dp_in.
- **Blanking.** blank_in[k]=1 forces seg=7'h7F and dp=1 for that digit.
- **Brightness.** A free-running BRIGHT_W-bit counter pwm increments every clock. The anode of digit idx is low only when pcnt ≥ GUARD and pwm ≤ bright.
- **Segment lines.** seg and dp always show the current digit's glyph, independent of PWM and guard; only an is gated.
- **Register contents.** Display and shadow registers hold their values until the next load or boundary. hex_en, lz_en and bright are sampled live every cycle.

## Timing
- **Reset.** On reset, registers take these values:
  - seg=7'h7F, dp=1, an all ones, frame_tick=0.
  - pcnt=0, idx=0, pwm=0, shadow and display registers all zero.
  - Reset overrides everything else, including mid-frame and mid-load.
- **Output latency.** All outputs are registered, one cycle after the counter state that produces them.
- **First lit anode after reset.** Goes low at cycle GUARD+1 (with bright all ones).
- **Frame period.** DIGITS*PRESCALE cycles.
- **frame_tick.** High for exactly one cycle, in the same output cycle as the first slot of digit 0.
- **Load-to-display latency.** Values loaded take effect at the next frame boundary: worst case DIGITS*PRESCALE cycles, plus the 1-cycle output register.
- **Consecutive loads.** With multiple loads in one frame, the last one wins.
- **Slot overlap.** Between slots, every anode is high for at least GUARD cycles, so no two anodes are ever low together.

## Test plan
- **Reset and first slot.** DIGITS=4, PRESCALE=16, GUARD=2, bright=4'hF. Reset, then load digits 0x1234. The first frame after load must show an=1110 with seg=0011001 (4), then 1101 / 0110000 (3), then 1011 / 0100100 (2), then 0111 / 1111001 (1). Each anode is high for 2 cycles at slot start, and frame_tick pulses every 64 cycles.
- **Hex vs decimal.** Digit value 0xB with hex_en=1 gives seg=0000011; with hex_en=0 it gives 0111111.
- **Leading zeros.** lz_en=1 with digits 0x0050 shows digits 3 and 2 as 1111111, digit 1 as 0010010 and digit 0 as 1000000. Digits 0x0000 show only digit 0 as 1000000.
- **Tear-free update.** Load 0xAAAA mid-frame. The remaining slots of that frame still show the old value; the new value appears starting at frame_tick. A load asserted in the same cycle as the boundary is displayed immediately.
- **Brightness.** BRIGHT_W=4. bright=3 gives anode low for 4 of every 16 cycles outside the guard; bright=15 gives it low for all non-guard cycles.
- **Reset mid-frame.** Assert reset during slot 2. Next cycle: an all ones, seg=7'h7F, dp=1. After release, scanning restarts at digit 0 and blank zero digits are displayed until the next load.

Source files
------------

// File: rtl/sevenseg_mux.sv
// sevenseg_mux: time-multiplexed seven-segment driver with tear-free double buffering, guard and PWM
module sevenseg_mux #(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 12500,
  parameter int GUARD    = 4,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  hex_en,
  input  logic                  lz_en,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);
  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic [4*DIGITS-1:0] sh_dig_q, sh_dig_d, ds_dig_q, ds_dig_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, ds_dp_q, ds_dp_d;
  logic [DIGITS-1:0]   sh_bl_q, sh_bl_d, ds_bl_q, ds_bl_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d, ft_q, ft_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                wrap, last, lz;
  logic [3:0]          val;

  function automatic logic [6:0] glyph(input logic [3:0] v, input logic hex);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return (!hex && v > 4'd9) ? 7'b0111111 : g;
  endfunction

  // Scan counters and buffers; a load landing on the frame boundary passes straight to the display copy
  always_comb begin
    wrap     = pcnt_q == PW'(PRESCALE - 1);
    last     = idx_q == IW'(DIGITS - 1);
    pcnt_d   = wrap ? '0 : pcnt_q + 1'b1;
    idx_d    = !wrap ? idx_q : last ? '0 : idx_q + 1'b1;
    pwm_d    = pwm_q + 1'b1;
    sh_dig_d = load ? digits_in : sh_dig_q;
    sh_dp_d  = load ? dp_in : sh_dp_q;
    sh_bl_d  = load ? blank_in : sh_bl_q;
    ds_dig_d = (wrap && last) ? sh_dig_d : ds_dig_q;
    ds_dp_d  = (wrap && last) ? sh_dp_d : ds_dp_q;
    ds_bl_d  = (wrap && last) ? sh_bl_d : ds_bl_q;
  end

  // Decode the digit under scan; only the anode is gated by guard and PWM
  always_comb begin
    val   = ds_dig_q[{idx_q, 2'b00} +: 4];
    lz    = lz_en && idx_q != '0 && (ds_dig_q >> {idx_q, 2'b00}) == '0;
    seg_d = (ds_bl_q[idx_q] || lz) ? 7'h7F : glyph(val, hex_en);
    dp_d  = ds_bl_q[idx_q] | ~ds_dp_q[idx_q];
    an_d  = (pcnt_q >= PW'(GUARD) && pwm_q <= bright) ? ~(DIGITS'(1) << idx_q) : '1;
    ft_d  = pcnt_q == '0 && idx_q == '0;
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_q   <= '0;
      idx_q    <= '0;
      pwm_q    <= '0;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_bl_q  <= '0;
      ds_dig_q <= '0;
      ds_dp_q  <= '0;
      ds_bl_q  <= '0;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      an_q     <= '1;
      ft_q     <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      pwm_q    <= pwm_d;
      sh_dig_q <= sh_dig_d;
      sh_dp_q  <= sh_dp_d;
      sh_bl_q  <= sh_bl_d;
      ds_dig_q <= ds_dig_d;
      ds_dp_q  <= ds_dp_d;
      ds_bl_q  <= ds_bl_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      ft_q     <= ft_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = ft_q;
endmodule

// File: tb/tb_sevenseg_mux.sv
// tb_sevenseg_mux: cycle-level check of sevenseg_mux against a frame/slot arithmetic model
module tb_sevenseg_mux;
  localparam int D = 4, P = 16, G = 2, F = D * P;
  localparam logic [6:0] GLY [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic clock = 0, reset = 1, load = 0, hex_en = 1, lz_en = 0;
  logic [15:0] digits_in = '0;
  logic [3:0] dp_in = '0, blank_in = '0, bright = 4'hF;
  logic [6:0] seg;
  logic dp, frame_tick;
  logic [3:0] an;
  int checks = 0, errs = 0, n = 0;
  logic [15:0] sh_dig = '0, ds_dig = '0;
  logic [3:0] sh_dp = '0, ds_dp = '0, sh_bl = '0, ds_bl = '0;

  sevenseg_mux #(.DIGITS(D), .PRESCALE(P), .GUARD(G), .BRIGHT_W(4)) dut (
    .clock(clock), .reset(reset), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .hex_en(hex_en), .lz_en(lz_en), .bright(bright),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s cycle=%0d got=%b exp=%b", tag, n, got, exp);
    end
  endtask

  task automatic step();
    int k, pc;
    logic [6:0] es;
    logic [3:0] ean, v;
    logic edp, eft, lz;
    if (reset) begin
      es = 7'h7F; edp = 1; ean = 4'hF; eft = 0; n = 0;
      sh_dig = '0; ds_dig = '0; sh_dp = '0; ds_dp = '0; sh_bl = '0; ds_bl = '0;
    end else begin
      pc  = n % P;
      k   = (n / P) % D;
      v   = ds_dig[4*k +: 4];
      lz  = lz_en && k > 0 && (ds_dig >> (4 * k)) == 0;
      es  = (ds_bl[k] || lz) ? 7'h7F : (!hex_en && v > 9) ? 7'b0111111 : GLY[v];
      edp = ds_bl[k] || !ds_dp[k];
      ean = (pc >= G && (n % 16) <= int'(bright)) ? ~(4'b1 << k) : 4'hF;
      eft = (n % F) == 0;
      if (n % F == F - 1) begin
        ds_dig = load ? digits_in : sh_dig;
        ds_dp  = load ? dp_in : sh_dp;
        ds_bl  = load ? blank_in : sh_bl;
      end
      if (load) begin
        sh_dig = digits_in; sh_dp = dp_in; sh_bl = blank_in;
      end
      n++;
    end
    @(posedge clock);
    #1;
    chk("seg", seg, es);
    chk("dp", {6'b0, dp}, {6'b0, edp});
    chk("an", {3'b0, an}, {3'b0, ean});
    chk("frame_tick", {6'b0, frame_tick}, {6'b0, eft});
  endtask

  task automatic run(input int c);
    repeat (c) step();
  endtask

  task automatic ld(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    digits_in = d; dp_in = p; blank_in = b; load = 1;
    step();
    load = 0;
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < F && n % F != ph; i++) step();
  endtask

  initial begin
    run(3);
    reset = 0;
    ld(16'h1234, 4'b0000, 4'b0000);
    run(130);
    ld(16'hBB0B, 4'b0101, 4'b0000);
    run(70);
    hex_en = 0;
    run(70);
    hex_en = 1;
    lz_en = 1;
    ld(16'h0050, 4'b0100, 4'b0000);
    run(130);
    ld(16'h0000, 4'b0000, 4'b0000);
    run(70);
    lz_en = 0;
    wait_phase(20);
    ld(16'hAAAA, 4'b0000, 4'b0000);
    run(100);
    wait_phase(F - 1);
    ld(16'h5678, 4'b1000, 4'b0010);
    run(70);
    bright = 4'd3;
    run(70);
    bright = 4'hF;
    run(20);
    repeat (25) begin
      hex_en = 1'($urandom);
      lz_en  = 1'($urandom);
      bright = 4'($urandom);
      ld(16'($urandom), 4'($urandom), 4'($urandom));
      run($urandom_range(1, 90));
    end
    bright = 4'hF;
    lz_en = 0;
    wait_phase(34);
    reset = 1;
    step();
    reset = 0;
    run(140);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
